// File: rtl/ama_riscv_widen_seq.sv
// SIMD widening sequencer: widens a 32-bit operand to 64 bits and drains it as two writeback beats (rd, rd+1).
// Optional perf counters are compiled in with AMA_RISCV_WIDEN_SEQ_PERF_EN.

package ama_riscv_widen_pkg;
  typedef enum logic [2:0] {
    WIDEN_OP_16  = 3'd0,
    WIDEN_OP_16U = 3'd1,
    WIDEN_OP_8   = 3'd2,
    WIDEN_OP_8U  = 3'd3,
    WIDEN_OP_4   = 3'd4,
    WIDEN_OP_4U  = 3'd5,
    WIDEN_OP_2   = 3'd6,
    WIDEN_OP_2U  = 3'd7
  } widen_op_t;
endpackage

module ama_riscv_data_fmt
  import ama_riscv_widen_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] data_i,
  output logic [63:0] s_o
);

  logic sgn_s;

  // Signedness of the selected op
  always_comb begin
    sgn_s = 1'b0;
    case (widen_op_t'(op_i))
      WIDEN_OP_16, WIDEN_OP_8, WIDEN_OP_4, WIDEN_OP_2: sgn_s = 1'b1;
      default: sgn_s = 1'b0;
    endcase
  end

  // Every element of the operand is extended to twice its width, in place order
  always_comb begin
    s_o = 64'd0;
    case (widen_op_t'(op_i))
      WIDEN_OP_16, WIDEN_OP_16U: begin
        for (int i = 0; i < 2; i++)
          s_o[i*32 +: 32] = {{16{sgn_s & data_i[i*16+15]}}, data_i[i*16 +: 16]};
      end
      WIDEN_OP_8, WIDEN_OP_8U: begin
        for (int i = 0; i < 4; i++)
          s_o[i*16 +: 16] = {{8{sgn_s & data_i[i*8+7]}}, data_i[i*8 +: 8]};
      end
      WIDEN_OP_4, WIDEN_OP_4U: begin
        for (int i = 0; i < 8; i++)
          s_o[i*8 +: 8] = {{4{sgn_s & data_i[i*4+3]}}, data_i[i*4 +: 4]};
      end
      WIDEN_OP_2, WIDEN_OP_2U: begin
        for (int i = 0; i < 16; i++)
          s_o[i*4 +: 4] = {{2{sgn_s & data_i[i*2+1]}}, data_i[i*2 +: 2]};
      end
      default: s_o = 64'd0;
    endcase
  end

endmodule

module ama_riscv_widen_seq_chk (
  input logic        clk,
  input logic        rst_n,
  input logic        wb_valid_i,
  input logic        wb_last_i,
  input logic        st_idle_i,
  input logic        st_lo_i,
  input logic        st_hi_i,
  input logic [31:0] wb_data_i,
  input logic [31:0] res_lo_i
);

  // A beat is presented exactly when the sequencer is busy; only HI may flag last
  always @(posedge clk) begin
    if (rst_n) begin
      assert (wb_valid_i == !st_idle_i);
      assert (!wb_last_i || st_hi_i);
      assert (!st_lo_i || (wb_data_i == res_lo_i));
    end
  end

endmodule

module ama_riscv_widen_seq #(
  parameter int RD_W    = 5,
  parameter bit SKIP_X0 = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      in_op_i,
  input  logic [31:0]     in_data_i,
  input  logic [RD_W-1:0] in_rd_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [RD_W-1:0] wb_rd_o,
  output logic [31:0]     wb_data_o,
  output logic            wb_last_o
`ifdef AMA_RISCV_WIDEN_SEQ_PERF_EN
  ,
  output logic [31:0]     perf_ops_o,
  output logic [31:0]     perf_stall_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_e;

  localparam logic [RD_W-1:0] RD_ONE  = {{(RD_W-1){1'b0}}, 1'b1};
  localparam logic [RD_W-1:0] RD_ZERO = {RD_W{1'b0}};

  state_e            state_q;
  logic [63:0]       res_q;
  logic [RD_W-1:0]   rd_q;
  logic              wb_valid_q;
  logic [RD_W-1:0]   wb_rd_q;
  logic [31:0]       wb_data_q;
  logic              wb_last_q;

  logic [63:0]       fmt_s;
  logic [RD_W-1:0]   rd_hi_s;
  logic [RD_W-1:0]   in_rd_hi_s;
  logic              skip_lo_s;
  logic              skip_hi_s;
  logic              retire_s;
  logic              in_ready_s;
  logic              accept_s;

  ama_riscv_data_fmt u_fmt (
    .op_i   (in_op_i),
    .data_i (in_data_i),
    .s_o    (fmt_s)
  );

  // Retire/accept decisions; a skipped HI lets the op retire on the LO handshake
  always_comb begin
    rd_hi_s    = rd_q + RD_ONE;
    in_rd_hi_s = in_rd_i + RD_ONE;
    skip_lo_s  = SKIP_X0 && (in_rd_i == RD_ZERO);
    skip_hi_s  = SKIP_X0 && (rd_hi_s == RD_ZERO);
    retire_s   = wb_ready_i && ((state_q == ST_HI) || ((state_q == ST_LO) && skip_hi_s));
    in_ready_s = !flush_i && ((state_q == ST_IDLE) || retire_s);
    accept_s   = in_valid_i && in_ready_s;
  end

  assign in_ready_o = in_ready_s;
  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;
  assign wb_last_o  = wb_last_q;

  // Beat sequencer: beat registers are loaded only on accept or after a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      res_q      <= 64'd0;
      rd_q       <= RD_ZERO;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= RD_ZERO;
      wb_data_q  <= 32'd0;
      wb_last_q  <= 1'b0;
    end else if (flush_i) begin
      state_q    <= ST_IDLE;
      wb_valid_q <= 1'b0;
      wb_last_q  <= 1'b0;
    end else if (accept_s) begin
      res_q      <= fmt_s;
      rd_q       <= in_rd_i;
      wb_valid_q <= 1'b1;
      if (skip_lo_s) begin
        state_q   <= ST_HI;
        wb_rd_q   <= in_rd_hi_s;
        wb_data_q <= fmt_s[63:32];
        wb_last_q <= 1'b1;
      end else begin
        state_q   <= ST_LO;
        wb_rd_q   <= in_rd_i;
        wb_data_q <= fmt_s[31:0];
        wb_last_q <= 1'b0;
      end
    end else if ((state_q == ST_LO) && wb_ready_i) begin
      if (skip_hi_s) begin
        state_q    <= ST_IDLE;
        wb_valid_q <= 1'b0;
        wb_last_q  <= 1'b0;
      end else begin
        state_q   <= ST_HI;
        wb_rd_q   <= rd_hi_s;
        wb_data_q <= res_q[63:32];
        wb_last_q <= 1'b1;
      end
    end else if ((state_q == ST_HI) && wb_ready_i) begin
      state_q    <= ST_IDLE;
      wb_valid_q <= 1'b0;
      wb_last_q  <= 1'b0;
    end else begin
      state_q <= state_q;
    end
  end

`ifdef AMA_RISCV_WIDEN_SEQ_PERF_EN
  logic [31:0] perf_ops_q;
  logic [31:0] perf_stall_q;

  // Retired-op and backpressure counters; frozen during flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops_q   <= 32'd0;
      perf_stall_q <= 32'd0;
    end else if (!flush_i) begin
      if (retire_s) begin
        perf_ops_q <= perf_ops_q + 32'd1;
      end
      if (wb_valid_q && !wb_ready_i) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_ops_o   = perf_ops_q;
  assign perf_stall_o = perf_stall_q;
`endif

  ama_riscv_widen_seq_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid_i (wb_valid_q),
    .wb_last_i  (wb_last_q),
    .st_idle_i  (state_q == ST_IDLE),
    .st_lo_i    (state_q == ST_LO),
    .st_hi_i    (state_q == ST_HI),
    .wb_data_i  (wb_data_q),
    .res_lo_i   (res_q[31:0])
  );

endmodule

// File: tb/tb_ama_riscv_widen_seq.sv
// Bench for ama_riscv_widen_seq: directed scenarios followed by random traffic against a beat-queue model.
module tb_ama_riscv_widen_seq;
  import ama_riscv_widen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  widen_op_t   in_op;
  logic [31:0] in_data;
  logic [4:0]  in_rd;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_last;
`ifdef AMA_RISCV_WIDEN_SEQ_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_stall;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ama_riscv_widen_seq #(.RD_W(5), .SKIP_X0(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_op_i    (in_op),
    .in_data_i  (in_data),
    .in_rd_i    (in_rd),
    .wb_valid_o (wb_valid),
    .wb_ready_i (wb_ready),
    .wb_rd_o    (wb_rd),
    .wb_data_o  (wb_data),
    .wb_last_o  (wb_last)
`ifdef AMA_RISCV_WIDEN_SEQ_PERF_EN
    ,
    .perf_ops_o   (perf_ops),
    .perf_stall_o (perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
    tests++;
    assert (obs_v === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs_v, exp_v);
    end
  endtask

  function automatic logic [63:0] beat(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic l);
    return {25'd0, v, rd, d, l};
  endfunction

  function automatic logic [63:0] obs();
    return beat(wb_valid, wb_rd, wb_data, wb_last);
  endfunction

  // Reference widening: pull each field out arithmetically, sign-adjust, repack at double width
  function automatic logic [63:0] widen_ref(input widen_op_t op, input logic [31:0] d);
    int w;
    bit sgn;
    longint v;
    logic [63:0] r;
    case (op)
      WIDEN_OP_16:  begin w = 16; sgn = 1'b1; end
      WIDEN_OP_16U: begin w = 16; sgn = 1'b0; end
      WIDEN_OP_8:   begin w = 8;  sgn = 1'b1; end
      WIDEN_OP_8U:  begin w = 8;  sgn = 1'b0; end
      WIDEN_OP_4:   begin w = 4;  sgn = 1'b1; end
      WIDEN_OP_4U:  begin w = 4;  sgn = 1'b0; end
      WIDEN_OP_2:   begin w = 2;  sgn = 1'b1; end
      default:      begin w = 2;  sgn = 1'b0; end
    endcase
    r = 64'd0;
    for (int i = 0; i < 32 / w; i++) begin
      v = longint'((d >> (i * w)) & ((32'd1 << w) - 32'd1));
      if (sgn && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
      r = r | ((64'(v) & ((64'd1 << (2 * w)) - 64'd1)) << (i * 2 * w));
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic [63:0] r1, r2, r3;
  logic [31:0] d1, d2;
  logic [63:0] exp_q[$];
  logic [63:0] exp_b, got_b;
  logic        exp_ready;
  logic [4:0]  hi_rd;
  int          ops_m, stall_m, sel;
`ifdef AMA_RISCV_WIDEN_SEQ_PERF_EN
  logic [31:0] ops_before;
`endif

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = WIDEN_OP_16;
    in_data = 32'd0; in_rd = 5'd0; wb_ready = 1'b0;
    #12;
    chk("reset_outputs", obs(), beat(1'b0, 5'd0, 32'd0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Signed byte widening with free-running writeback
    in_valid = 1'b1; in_op = WIDEN_OP_8; in_data = 32'h80FF017F; in_rd = 5'd4; wb_ready = 1'b1;
    sample(); chk("t1_ready_idle", 64'(in_ready), 64'd1);
    tick(); in_valid = 1'b0;
    sample(); chk("t1_lo", obs(), beat(1'b1, 5'd4, 32'h0001007F, 1'b0));
    tick(); sample(); chk("t1_hi", obs(), beat(1'b1, 5'd5, 32'hFF80FFFF, 1'b1));
    tick(); sample(); chk("t1_idle", 64'(wb_valid), 64'd0);

    // LO beat held under backpressure
    tick();
    in_valid = 1'b1; in_op = WIDEN_OP_16U; in_data = 32'h8000FFFF; in_rd = 5'd10; wb_ready = 1'b0;
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_ready = (i == 3);
      sample();
      chk("t2_lo_hold", obs(), beat(1'b1, 5'd10, 32'h0000FFFF, 1'b0));
      chk("t2_ready_lo", 64'(in_ready), 64'd0);
      tick();
    end
    sample(); chk("t2_hi", obs(), beat(1'b1, 5'd11, 32'h00008000, 1'b1));
    tick(); sample(); chk("t2_idle", 64'(wb_valid), 64'd0);

    // Back-to-back ops with no bubble
    d1 = $urandom; d2 = $urandom;
    r1 = widen_ref(WIDEN_OP_4, d1); r2 = widen_ref(WIDEN_OP_4, d2);
    tick();
    in_valid = 1'b1; in_op = WIDEN_OP_4; in_data = d1; in_rd = 5'd7; wb_ready = 1'b1;
    tick(); in_valid = 1'b0;
    sample(); chk("t3_lo1", obs(), beat(1'b1, 5'd7, r1[31:0], 1'b0));
    tick(); in_valid = 1'b1; in_data = d2; in_rd = 5'd20;
    sample(); chk("t3_hi1", obs(), beat(1'b1, 5'd8, r1[63:32], 1'b1));
    chk("t3_ready_hi1", 64'(in_ready), 64'd1);
    tick(); in_valid = 1'b0;
    sample(); chk("t3_lo2", obs(), beat(1'b1, 5'd20, r2[31:0], 1'b0));
    tick(); sample(); chk("t3_hi2", obs(), beat(1'b1, 5'd21, r2[63:32], 1'b1));
    chk("t3_ready_hi2", 64'(in_ready), 64'd1);
    tick(); sample(); chk("t3_idle", 64'(wb_valid), 64'd0);

    // rd=31: HI targets x0 and is skipped
`ifdef AMA_RISCV_WIDEN_SEQ_PERF_EN
    ops_before = perf_ops;
`endif
    tick();
    in_valid = 1'b1; in_op = WIDEN_OP_2U; in_data = 32'hFFFFFFFF; in_rd = 5'd31; wb_ready = 1'b1;
    tick(); in_valid = 1'b0;
    sample(); chk("t4_lo_only", obs(), beat(1'b1, 5'd31, 32'h33333333, 1'b0));
    chk("t4_ready_retire", 64'(in_ready), 64'd1);
    tick(); sample(); chk("t4_no_hi", 64'(wb_valid), 64'd0);
`ifdef AMA_RISCV_WIDEN_SEQ_PERF_EN
    chk("t4_perf_ops", 64'(perf_ops), 64'(ops_before + 32'd1));
`endif

    // rd=0: LO targets x0, HI presented first
    tick();
    in_valid = 1'b1; in_op = WIDEN_OP_16; in_data = 32'h12348765; in_rd = 5'd0;
    tick(); in_valid = 1'b0;
    sample(); chk("rd0_hi_first", obs(), beat(1'b1, 5'd1, 32'h00001234, 1'b1));
    tick(); sample(); chk("rd0_idle", 64'(wb_valid), 64'd0);

    // Flush during a stalled LO; a same-cycle request is refused
    r3 = widen_ref(WIDEN_OP_8U, 32'hA5A5A5A5);
    tick();
    in_valid = 1'b1; in_op = WIDEN_OP_8U; in_data = 32'hA5A5A5A5; in_rd = 5'd3; wb_ready = 1'b0;
    tick(); in_rd = 5'd9; flush = 1'b1;
    sample(); chk("t5_lo_pre", obs(), beat(1'b1, 5'd3, r3[31:0], 1'b0));
    chk("t5_ready_flush", 64'(in_ready), 64'd0);
    tick(); flush = 1'b0; in_valid = 1'b0;
    sample(); chk("t5_flushed", 64'(wb_valid), 64'd0);
    chk("t5_ready_after", 64'(in_ready), 64'd1);
    tick(); wb_ready = 1'b1;
    sample(); chk("t5_no_hi", 64'(wb_valid), 64'd0);

    // Asynchronous reset while a HI beat is stalled
    d1 = $urandom; r1 = widen_ref(WIDEN_OP_16, d1);
    tick();
    in_valid = 1'b1; in_op = WIDEN_OP_16; in_data = d1; in_rd = 5'd12; wb_ready = 1'b1;
    tick(); in_valid = 1'b0;
    tick(); wb_ready = 1'b0;
    sample(); chk("t6_in_hi", obs(), beat(1'b1, 5'd13, r1[63:32], 1'b1));
    #2 rst_n = 1'b0;
    #1 chk("t6_async_drop", obs(), beat(1'b0, 5'd0, 32'd0, 1'b0));
    #1 rst_n = 1'b1;
    tick(); sample();
    chk("t6_ready_after", 64'(in_ready), 64'd1);
    chk("t6_idle_after", 64'(wb_valid), 64'd0);
`ifdef AMA_RISCV_WIDEN_SEQ_PERF_EN
    chk("t6_perf_ops_zero", 64'(perf_ops), 64'd0);
    chk("t6_perf_stall_zero", 64'(perf_stall), 64'd0);
`endif

    // Random traffic: the model is the list of beats still owed to writeback
    ops_m = 0; stall_m = 0;
    for (int c = 0; c < 500; c++) begin
      tick();
      flush    = ($urandom_range(0, 31) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_op    = widen_op_t'($urandom_range(0, 7));
      in_data  = $urandom;
      sel      = $urandom_range(0, 7);
      in_rd    = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd31 : 5'($urandom_range(0, 31));
      wb_ready = ($urandom_range(0, 3) != 0);
      sample();
      exp_ready = !flush && ((exp_q.size() == 0) || ((exp_q.size() == 1) && wb_ready));
      chk("rnd_ready", 64'(in_ready), 64'(exp_ready));
      exp_b = (exp_q.size() != 0) ? exp_q[0] : beat(1'b0, 5'd0, 32'd0, 1'b0);
      got_b = wb_valid ? obs() : beat(1'b0, 5'd0, 32'd0, 1'b0);
      chk("rnd_beat", got_b, exp_b);
      if (flush) begin
        exp_q.delete();
      end else begin
        if ((exp_q.size() != 0) && !wb_ready) stall_m++;
        if ((exp_q.size() != 0) && wb_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) ops_m++;
        end
        if (in_valid && exp_ready) begin
          r1 = widen_ref(in_op, in_data);
          hi_rd = in_rd + 5'd1;
          if (in_rd != 5'd0) exp_q.push_back(beat(1'b1, in_rd, r1[31:0], 1'b0));
          if (hi_rd != 5'd0) exp_q.push_back(beat(1'b1, hi_rd, r1[63:32], 1'b1));
        end
      end
    end
`ifdef AMA_RISCV_WIDEN_SEQ_PERF_EN
    tick(); sample();
    chk("rnd_perf_ops", 64'(perf_ops), 64'(ops_m));
    chk("rnd_perf_stall", 64'(perf_stall), 64'(stall_m));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
